gp_cmd_parser: RTL
==================

Name: gp_cmd_parser

Overview:
- Consumes the 32-bit command word stream produced by the graphics-processor command FIFO (fifo_GP_out), one word per handshake.
- Decodes FILL, LINE and STOP commands and dispatches them to the fill engine and line engine through valid/ready pairs.
- Raises a one-cycle done pulse at STOP, which the GP interrupt logic samples.
- Sits directly downstream of the command FIFO and upstream of the pixel engines.

Parameters:
- H_MAX, 799, largest legal x coordinate; larger x values are clamped to this.
- V_MAX, 599, largest legal y coordinate; larger y values are clamped to this.
- CNT_W, 16, width of the executed-command counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- gp_start  in  1  one-cycle pulse; begins parsing a new command list
- cmd_word  in  32  command word from FIFO (fifo_GP_out)
- cmd_valid  in  1  cmd_word holds a valid word
- cmd_rd_en  out  1  word consumed this cycle when cmd_valid & cmd_rd_en
- fill_valid  out  1  fill request pending
- fill_ready  in  1  fill engine accepts the request
- fill_color  out  24  fill colour
- line_valid  out  1  line request pending
- line_ready  in  1  line engine accepts the request
- line_color  out  24  line colour
- line_x0, line_x1  out  10  line endpoint x, clamped
- line_y0, line_y1  out  10  line endpoint y, clamped
- gp_busy  out  1  high in any state other than IDLE
- gp_done  out  1  one-cycle pulse when STOP is decoded
- cmd_err  out  1  one-cycle pulse when an unknown opcode is decoded
- cmd_count  out  CNT_W  FILL plus LINE commands issued since the last gp_start

Behaviour:
- Reset: state is IDLE; all outputs are 0, including cmd_count and all colour and coordinate registers.
- Word formats:
  - Opcode is cmd_word[31:24].
  - 0x00 = STOP.
  - 0x01 = FILL; colour is [23:0].
  - 0x02 = LINE; colour is [23:0]. It is followed by two coordinate words, P0 then P1, with x in [25:16] and y in [9:0]. All other bits are ignored.
  - Any other opcode is unknown.
- States: IDLE, FETCH, LINE_P0, LINE_P1, ISSUE_FILL, ISSUE_LINE, DONE.
- cmd_rd_en = cmd_valid & (state is FETCH, LINE_P0 or LINE_P1). It is driven from registered state only, with no combinational path to the ready inputs.
- IDLE:
  - Does not consume words.
  - On gp_start, clears cmd_count and moves to FETCH.
  - gp_start in any other state is ignored.
- FETCH, on handshake:
  - FILL: latch colour, go to ISSUE_FILL.
  - LINE: latch colour, go to LINE_P0.
  - STOP: go to DONE.
  - Unknown: pulse cmd_err the next cycle and stay in FETCH, so the word is skipped.
  - No handshake: hold state.
- LINE_P0, on handshake: latch clamped x0/y0, go to LINE_P1.
- LINE_P1, on handshake: latch clamped x1/y1, go to ISSUE_LINE.
- Clamping rule: x_out = (x > H_MAX) ? H_MAX : x; likewise y against V_MAX. The comparison is unsigned 10-bit.
- ISSUE_FILL:
  - fill_valid is high.
  - fill_color is stable while fill_valid is high and fill_ready is low.
  - On fill_ready: cmd_count increments, go to FETCH.
  - fill_valid drops the cycle after acceptance.
- ISSUE_LINE: same rules as ISSUE_FILL, using line_valid, line_ready and all line_* outputs.
- DONE: gp_done is high for exactly one cycle, then go to IDLE.
- Latency:
  - The first request valid appears 1 cycle after the last word of its command is consumed.
  - Back-to-back, the next command's first word can be consumed the cycle after the previous request is accepted.
- fill_valid and line_valid are never high together.
- cmd_count wraps modulo 2^CNT_W.
- Ready inputs asserted while the matching valid is low are ignored.
- cmd_valid low in the middle of a LINE command (between words): wait indefinitely in LINE_P0 or LINE_P1 and hold the latched fields.
- rst mid-operation: immediate return to IDLE with all outputs 0. A pending request is dropped without handshake.
- Data outputs (colour, coordinates) hold their last value after the request is accepted, until they are overwritten.

Test Plan:
- Reset, then gp_start. Feed 0x01FF00AA then 0x00000000 with fill_ready=1 -> fill_valid for 1 cycle with fill_color=0xFF00AA; gp_done pulses once; cmd_count=1; state returns to IDLE.
- LINE: feed 0x02123456, 0x0064_00C8, 0x03FF_03FF; hold line_ready=0 for 5 cycles, then set it to 1 -> line_color=0x123456, x0=100, y0=200, x1=799, y1=599; values stable during the stall; single acceptance.
- Toggle cmd_valid every other cycle during a LINE command -> coordinates are latched only on handshake cycles; the result is identical to the unstalled case.
- Feed 0x7F000000, then FILL 0x01000001, then STOP -> cmd_err pulses once; the FILL still issues; cmd_count=1.
- Feed words while in IDLE without gp_start -> cmd_rd_en stays 0 and nothing is consumed. Assert rst during ISSUE_LINE -> next cycle line_valid=0, state IDLE, cmd_count=0.
- Issue 65537 FILLs with fill_ready tied to 1 -> cmd_count=1 (wrap); no cycle has fill_valid and line_valid both high.

Source files
------------

// File: rtl/gp_cmd_parser_if.sv
// Command-stream and engine-dispatch signals of the graphics-processor command parser.
// The slave modport is the parser; the master modport is the FIFO/engine/host side.
interface gp_cmd_parser_if #(
    parameter int CNT_W = 16
);
    logic             gp_start;
    logic [31:0]      cmd_word;
    logic             cmd_valid;
    logic             cmd_rd_en;
    logic             fill_valid;
    logic             fill_ready;
    logic [23:0]      fill_color;
    logic             line_valid;
    logic             line_ready;
    logic [23:0]      line_color;
    logic [9:0]       line_x0;
    logic [9:0]       line_y0;
    logic [9:0]       line_x1;
    logic [9:0]       line_y1;
    logic             gp_busy;
    logic             gp_done;
    logic             cmd_err;
    logic [CNT_W-1:0] cmd_count;

    modport slave (
        input  gp_start, cmd_word, cmd_valid, fill_ready, line_ready,
        output cmd_rd_en, fill_valid, fill_color, line_valid, line_color,
               line_x0, line_y0, line_x1, line_y1, gp_busy, gp_done, cmd_err, cmd_count
    );

    modport master (
        output gp_start, cmd_word, cmd_valid, fill_ready, line_ready,
        input  cmd_rd_en, fill_valid, fill_color, line_valid, line_color,
               line_x0, line_y0, line_x1, line_y1, gp_busy, gp_done, cmd_err, cmd_count
    );
endinterface

// File: rtl/gp_cmd_parser.sv
// Graphics-processor command parser: decodes FILL/LINE/STOP words from the command FIFO
// and dispatches fill and line requests to the pixel engines over valid/ready pairs.
module gp_cmd_parser #(
    parameter int H_MAX = 799,
    parameter int V_MAX = 599,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    gp_cmd_parser_if.slave bus
);
    localparam logic [9:0] H_LIM = 10'(H_MAX);
    localparam logic [9:0] V_LIM = 10'(V_MAX);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_LINE_P0    = 3'd2,
        ST_LINE_P1    = 3'd3,
        ST_ISSUE_FILL = 3'd4,
        ST_ISSUE_LINE = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    state_t           state_r;
    logic             fill_valid_r;
    logic             line_valid_r;
    logic [23:0]      fill_color_r;
    logic [23:0]      line_color_r;
    logic [9:0]       line_x0_r;
    logic [9:0]       line_y0_r;
    logic [9:0]       line_x1_r;
    logic [9:0]       line_y1_r;
    logic             gp_busy_r;
    logic             gp_done_r;
    logic             cmd_err_r;
    logic [CNT_W-1:0] cmd_count_r;

    logic             rd_en_s;
    logic             handshake_s;
    logic [7:0]       opcode_s;
    logic [9:0]       x_clamped_s;
    logic [9:0]       y_clamped_s;

    function automatic logic [9:0] clamp_coord(input logic [9:0] v, input logic [9:0] lim);
        logic [9:0] r;
        if (v > lim) begin
            r = lim;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Read enable depends only on registered state, never on the engine ready inputs.
    assign rd_en_s     = bus.cmd_valid & ((state_r == ST_FETCH) | (state_r == ST_LINE_P0) |
                                          (state_r == ST_LINE_P1));
    assign handshake_s = rd_en_s;
    assign opcode_s    = bus.cmd_word[31:24];
    assign x_clamped_s = clamp_coord(bus.cmd_word[25:16], H_LIM);
    assign y_clamped_s = clamp_coord(bus.cmd_word[9:0], V_LIM);

    // Parser FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            fill_valid_r <= 1'b0;
            line_valid_r <= 1'b0;
            fill_color_r <= 24'd0;
            line_color_r <= 24'd0;
            line_x0_r    <= 10'd0;
            line_y0_r    <= 10'd0;
            line_x1_r    <= 10'd0;
            line_y1_r    <= 10'd0;
            gp_busy_r    <= 1'b0;
            gp_done_r    <= 1'b0;
            cmd_err_r    <= 1'b0;
            cmd_count_r  <= '0;
        end else begin
            gp_done_r <= 1'b0;
            cmd_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.gp_start) begin
                        cmd_count_r <= '0;
                        gp_busy_r   <= 1'b1;
                        state_r     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (handshake_s) begin
                        case (opcode_s)
                            8'h00: begin
                                gp_done_r <= 1'b1;
                                state_r   <= ST_DONE;
                            end
                            8'h01: begin
                                fill_color_r <= bus.cmd_word[23:0];
                                fill_valid_r <= 1'b1;
                                state_r      <= ST_ISSUE_FILL;
                            end
                            8'h02: begin
                                line_color_r <= bus.cmd_word[23:0];
                                state_r      <= ST_LINE_P0;
                            end
                            // Unknown opcode: flag it and skip the word.
                            default: cmd_err_r <= 1'b1;
                        endcase
                    end
                end
                ST_LINE_P0: begin
                    if (handshake_s) begin
                        line_x0_r <= x_clamped_s;
                        line_y0_r <= y_clamped_s;
                        state_r   <= ST_LINE_P1;
                    end
                end
                ST_LINE_P1: begin
                    if (handshake_s) begin
                        line_x1_r    <= x_clamped_s;
                        line_y1_r    <= y_clamped_s;
                        line_valid_r <= 1'b1;
                        state_r      <= ST_ISSUE_LINE;
                    end
                end
                ST_ISSUE_FILL: begin
                    if (bus.fill_ready) begin
                        fill_valid_r <= 1'b0;
                        cmd_count_r  <= cmd_count_r + CNT_W'(1);
                        state_r      <= ST_FETCH;
                    end
                end
                ST_ISSUE_LINE: begin
                    if (bus.line_ready) begin
                        line_valid_r <= 1'b0;
                        cmd_count_r  <= cmd_count_r + CNT_W'(1);
                        state_r      <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    gp_busy_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    fill_valid_r <= 1'b0;
                    line_valid_r <= 1'b0;
                    gp_busy_r    <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_rd_en  = rd_en_s;
    assign bus.fill_valid = fill_valid_r;
    assign bus.fill_color = fill_color_r;
    assign bus.line_valid = line_valid_r;
    assign bus.line_color = line_color_r;
    assign bus.line_x0    = line_x0_r;
    assign bus.line_y0    = line_y0_r;
    assign bus.line_x1    = line_x1_r;
    assign bus.line_y1    = line_y1_r;
    assign bus.gp_busy    = gp_busy_r;
    assign bus.gp_done    = gp_done_r;
    assign bus.cmd_err    = cmd_err_r;
    assign bus.cmd_count  = cmd_count_r;
endmodule
